// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample/frame widths and frame field positions.
// Used by both the transmitter and the serdes receiver.
package i2s_pkg;
   localparam int SAMPLE_BITS       = 16;
   localparam int FRAME_BITS        = 32;
   localparam int DEFAULT_SLOT_BITS = 32;
   localparam int L_LSB             = 0;
   localparam int R_LSB             = 16;

   typedef logic [FRAME_BITS-1:0] frame_t;
endpackage

// File: rtl/i2s_slot_counter.sv
// Frame position counter for I2S: wraps over two channel slots, decodes
// lrclk, and flags the last count of the frame (the load boundary).
module i2s_slot_counter
   import i2s_pkg::*;
#(
   parameter int SLOT_BITS = DEFAULT_SLOT_BITS
)
(
   input  logic                           bclk,
   input  logic                           rstn,
   output logic [$clog2(2*SLOT_BITS)-1:0] cnt_nxt,
   output logic                           lrclk,
   output logic                           boundary
);
   localparam int            CW          = $clog2(2*SLOT_BITS);
   localparam logic [CW-1:0] LAST        = CW'(2*SLOT_BITS-1);
   localparam logic [CW-1:0] RIGHT_START = CW'(SLOT_BITS);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          lrclk_q, lrclk_d;

   always_comb begin
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      lrclk_d = (cnt_d >= RIGHT_START);
   end

   // Reset parks on the last count so the first edge after release is a boundary.
   always_ff @(posedge bclk or negedge rstn) begin
      if (!rstn) begin
         cnt_q   <= LAST;
         lrclk_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         lrclk_q <= lrclk_d;
      end
   end

   assign cnt_nxt  = cnt_d;
   assign lrclk    = lrclk_q;
   assign boundary = (cnt_q == LAST);
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: pops one stereo frame per frame period and serialises it
// MSB-first with one-BCLK data delay. Build option: I2S_TX_HOLD_ON_UNDERRUN_EN.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int SLOT_BITS = DEFAULT_SLOT_BITS
)
(
   input  logic        bclk,
   input  logic        rstn,
   input  logic [31:0] frame,
   input  logic        empty,
   output logic        rd,
   output logic        lrclk,
   output logic        sdata,
   output logic        underrun
);
   localparam int CW = $clog2(2*SLOT_BITS);

   if (SLOT_BITS < SAMPLE_BITS + 1 || SLOT_BITS > 64) begin : g_bad_slot
      $error("i2s_tx: SLOT_BITS out of range 17..64");
   end

   logic [CW-1:0] cnt_nxt;
   logic          boundary;
   frame_t        hold_q, hold_d;
   logic          rd_q, rd_d;
   logic          underrun_q, underrun_d;
   logic          sdata_q, sdata_d;
   int            pos;

   i2s_slot_counter #(.SLOT_BITS(SLOT_BITS)) u_slot_counter (
      .bclk     (bclk),
      .rstn     (rstn),
      .cnt_nxt  (cnt_nxt),
      .lrclk    (lrclk),
      .boundary (boundary)
   );

   always_comb begin
      hold_d     = hold_q;
      rd_d       = 1'b0;
      underrun_d = 1'b0;
      if (boundary) begin
         if (!empty) begin
            hold_d = frame;
            rd_d   = 1'b1;
         end else begin
            underrun_d = 1'b1;
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
            hold_d = hold_q;
`else
            hold_d = '0;
`endif
         end
      end

      // Bit choice follows the count being entered; hold is already loaded by cnt=1.
      pos     = int'(cnt_nxt);
      sdata_d = 1'b0;
      if (pos >= 1 && pos <= SAMPLE_BITS)
         sdata_d = hold_q[5'(L_LSB + SAMPLE_BITS - pos)];
      else if (pos >= SLOT_BITS + 1 && pos <= SLOT_BITS + SAMPLE_BITS)
         sdata_d = hold_q[5'(R_LSB + SLOT_BITS + SAMPLE_BITS - pos)];
   end

   always_ff @(posedge bclk or negedge rstn) begin
      if (!rstn) begin
         hold_q     <= '0;
         rd_q       <= 1'b0;
         underrun_q <= 1'b0;
         sdata_q    <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         rd_q       <= rd_d;
         underrun_q <= underrun_d;
         sdata_q    <= sdata_d;
      end
   end

   assign rd       = rd_q;
   assign underrun = underrun_q;
   assign sdata    = sdata_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a 32-bit-slot instance fed from a queue FIFO and
// a 17-bit-slot instance fed a constant frame, checked cycle by cycle.
module tb_i2s_tx;
   logic        bclk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] frame32, frame17;
   logic        empty32, empty17;
   logic        rd32, lrclk32, sdata32, ur32;
   logic        rd17, lrclk17, sdata17, ur17;

   logic [31:0] fq[$];
   int          n_checks = 0;
   int          n_fail   = 0;

`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
   localparam logic [31:0] UR_EXP = 32'h1111_2222;
`else
   localparam logic [31:0] UR_EXP = 32'h0;
`endif

   always #5 bclk = ~bclk;

   i2s_tx #(.SLOT_BITS(32)) dut32 (
      .bclk(bclk), .rstn(rstn), .frame(frame32), .empty(empty32),
      .rd(rd32), .lrclk(lrclk32), .sdata(sdata32), .underrun(ur32)
   );

   i2s_tx #(.SLOT_BITS(17)) dut17 (
      .bclk(bclk), .rstn(rstn), .frame(frame17), .empty(empty17),
      .rd(rd17), .lrclk(lrclk17), .sdata(sdata17), .underrun(ur17)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fifo_sync();
      empty32 = (fq.size() == 0);
      frame32 = (fq.size() != 0) ? fq[0] : 32'h0;
   endtask

   function automatic logic exp_bit(input int s, input logic [31:0] f, input int c);
      if (c >= 1 && c <= 16)         return f[5'(16 - c)];
      if (c >= s + 1 && c <= s + 16) return f[5'(32 + s - c)];
      return 1'b0;
   endfunction

   task automatic check_frame(input int s, input logic [31:0] f, input logic erd,
                              input logic eur, input int push_at,
                              input logic [31:0] push_val, input int stop_at,
                              input string tag);
      logic lr, sd, r, u;
      for (int c = 0; c < 2 * s; c++) begin
         @(posedge bclk);
         #1;
         lr = (s == 17) ? lrclk17 : lrclk32;
         sd = (s == 17) ? sdata17 : sdata32;
         r  = (s == 17) ? rd17    : rd32;
         u  = (s == 17) ? ur17    : ur32;
         chk($sformatf("%s lrclk c%0d", tag, c), {31'b0, lr}, {31'b0, (c >= s)});
         chk($sformatf("%s sdata c%0d", tag, c), {31'b0, sd}, {31'b0, exp_bit(s, f, c)});
         chk($sformatf("%s rd c%0d", tag, c), {31'b0, r}, {31'b0, (erd && c == 0)});
         chk($sformatf("%s underrun c%0d", tag, c), {31'b0, u}, {31'b0, (eur && c == 0)});
         if (s == 32 && rd32) begin
            void'(fq.pop_front());
            fifo_sync();
         end
         if (c == push_at) begin
            fq.push_back(push_val);
            fifo_sync();
         end
         if (c == stop_at) break;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " lrclk32"}, {31'b0, lrclk32}, 32'h1);
      chk({tag, " sdata32"}, {31'b0, sdata32}, 32'h0);
      chk({tag, " rd32"},    {31'b0, rd32},    32'h0);
      chk({tag, " ur32"},    {31'b0, ur32},    32'h0);
      chk({tag, " lrclk17"}, {31'b0, lrclk17}, 32'h1);
      chk({tag, " rd17"},    {31'b0, rd17},    32'h0);
   endtask

   initial begin
      frame17 = 32'hA5A5_1234;
      empty17 = 1'b0;
      fq.push_back(32'hA5A5_1234);
      fifo_sync();
      rstn = 1'b0;
      repeat (3) @(negedge bclk);
      check_reset_outputs("reset");

      fq.push_back(32'h8001_7FFE);
      fq.push_back(32'h0000_FFFF);
      fifo_sync();
      rstn = 1'b1;
      check_frame(32, 32'hA5A5_1234, 1'b1, 1'b0, -1, 32'h0, -1, "release");
      check_frame(32, 32'h8001_7FFE, 1'b1, 1'b0, -1, 32'h0, -1, "loop0");
      fq.push_back(32'h1111_2222);
      fifo_sync();
      check_frame(32, 32'h0000_FFFF, 1'b1, 1'b0, -1, 32'h0, -1, "loop1");
      check_frame(32, 32'h1111_2222, 1'b1, 1'b0, -1, 32'h0, -1, "pre_ur");

      // Empty at the boundary; a frame shows up mid-frame and must wait.
      check_frame(32, UR_EXP, 1'b0, 1'b1, 10, 32'hDEAD_BEEF, -1, "underrun");
      fq.push_back(32'h1357_9BDF);
      fifo_sync();
      check_frame(32, 32'hDEAD_BEEF, 1'b1, 1'b0, -1, 32'h0, -1, "late_frame");

      check_frame(32, 32'h1357_9BDF, 1'b1, 1'b0, -1, 32'h0, 20, "pre_rst");
      #2 rstn = 1'b0;
      #1 check_reset_outputs("async_rst");
      @(negedge bclk);
      @(negedge bclk);
      rstn = 1'b1;
      // Queue is empty at release, and reset cleared hold, so silence in both builds.
      check_frame(32, 32'h0, 1'b0, 1'b1, 5, 32'h0F0F_F0F0, -1, "post_rst");
      check_frame(32, 32'h0F0F_F0F0, 1'b1, 1'b0, -1, 32'h0, -1, "post_rst2");

      @(negedge bclk);
      rstn = 1'b0;
      @(negedge bclk);
      check_reset_outputs("reset17");
      rstn = 1'b1;
      check_frame(17, 32'hA5A5_1234, 1'b1, 1'b0, -1, 32'h0, -1, "slot17a");
      check_frame(17, 32'hA5A5_1234, 1'b1, 1'b0, -1, 32'h0, -1, "slot17b");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
